// File: rtl/sram22_march_bist.sv
// rtl/sram22_march_bist.sv - March C- self-test engine driving one sram22 single-port macro
// Issues one op per cycle, compares read data one cycle later and latches the first mismatch.
module sram22_march_bist #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [2:0]          LAST_ELEM = 3'd5;
  localparam logic [ADDR_WIDTH:0] ADDR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [2:0]             elem_q, elem_d;
  logic                   phase_q, phase_d;
  logic                   op_valid_q, op_valid_d;
  logic                   sram_we_q, sram_we_d;
  logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;
  logic                   tag_valid_q, tag_valid_d;
  logic [ADDR_WIDTH-1:0]  tag_addr_q, tag_addr_d;
  logic [2:0]             tag_elem_q, tag_elem_d;
  logic [DATA_WIDTH-1:0]  tag_exp_q, tag_exp_d;
  logic                   fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [2:0]             fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0]  fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;

  logic [ADDR_WIDTH:0]    addr_inc, addr_dec;
  logic                   down, terminal, last_phase, last_op;
  logic [2:0]             nxt_elem;
  logic [ADDR_WIDTH-1:0]  nxt_addr;
  logic                   nxt_phase, nxt_write;
  logic                   mismatch;

  // Sequencer: position of the op after the one currently on the SRAM port.
  // The extra counter bit acts as the terminal flag for both directions.
  always_comb begin
    addr_inc   = {1'b0, sram_addr_q} + ADDR_ONE;
    addr_dec   = {1'b0, sram_addr_q} - ADDR_ONE;
    down       = (elem_q == 3'd3) || (elem_q == 3'd4);
    terminal   = down ? addr_dec[ADDR_WIDTH] : addr_inc[ADDR_WIDTH];
    last_phase = (elem_q == 3'd0) || (elem_q == LAST_ELEM) || phase_q;
    last_op    = (elem_q == LAST_ELEM) && terminal;
    nxt_elem   = elem_q;
    nxt_addr   = sram_addr_q;
    nxt_phase  = 1'b1;
    if (last_phase) begin
      nxt_phase = 1'b0;
      if (terminal) begin
        nxt_elem = elem_q + 3'd1;
        nxt_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
      end else begin
        nxt_addr = down ? addr_dec[ADDR_WIDTH-1:0] : addr_inc[ADDR_WIDTH-1:0];
      end
    end
    nxt_write = (nxt_elem == 3'd0) || nxt_phase;
  end

  assign mismatch = tag_valid_q && !fail_q && (sram_dout != tag_exp_q);

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    op_valid_d   = 1'b0;
    sram_we_d    = 1'b0;
    sram_wmask_d = '1;
    sram_addr_d  = sram_addr_q;
    sram_din_d   = sram_din_q;
    tag_valid_d  = op_valid_q && !sram_we_q;
    tag_addr_d   = sram_addr_q;
    tag_elem_d   = elem_q;
    tag_exp_d    = {DATA_WIDTH{~elem_q[0]}};
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_elem_d  = fail_elem_q;
    fail_exp_d   = fail_exp_q;
    fail_data_d  = fail_data_q;

    if (mismatch) begin
      fail_d      = 1'b1;
      fail_addr_d = tag_addr_q;
      fail_elem_d = tag_elem_q;
      fail_exp_d  = tag_exp_q;
      fail_data_d = sram_dout;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          phase_d     = 1'b0;
          op_valid_d  = 1'b1;
          sram_we_d   = 1'b1;
          sram_addr_d = '0;
          sram_din_d  = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_exp_d  = '0;
          fail_data_d = '0;
        end
      end
      S_RUN: begin
        if (mismatch || last_op) begin
          state_d = S_DRAIN;
        end else begin
          elem_d      = nxt_elem;
          phase_d     = nxt_phase;
          op_valid_d  = 1'b1;
          sram_we_d   = nxt_write;
          sram_addr_d = nxt_addr;
          if (nxt_write) sram_din_d = {DATA_WIDTH{nxt_elem[0]}};
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      elem_q       <= '0;
      phase_q      <= 1'b0;
      op_valid_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wmask_q <= '1;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      tag_valid_q  <= 1'b0;
      tag_addr_q   <= '0;
      tag_elem_q   <= '0;
      tag_exp_q    <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
      fail_exp_q   <= '0;
      fail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      phase_q      <= phase_d;
      op_valid_q   <= op_valid_d;
      sram_we_q    <= sram_we_d;
      sram_wmask_q <= sram_wmask_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      tag_valid_q  <= tag_valid_d;
      tag_addr_q   <= tag_addr_d;
      tag_elem_q   <= tag_elem_d;
      tag_exp_q    <= tag_exp_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_elem_q  <= fail_elem_d;
      fail_exp_q   <= fail_exp_d;
      fail_data_q  <= fail_data_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_elem     = fail_elem_q;
  assign fail_expected = fail_exp_q;
  assign fail_data     = fail_data_q;
  assign sram_we       = sram_we_q;
  assign sram_wmask    = sram_wmask_q;
  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;

endmodule

// File: tb/tb_sram22_march_bist.sv
// tb/tb_sram22_march_bist.sv - bench for sram22_march_bist with a faulty-SRAM model and March reference
// The reference expands March C- element by element into an op list and predicts the first mismatch.
module tb_sram22_march_bist;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int WMW = 1;
  localparam int N = 512;
  localparam int CAP = 10 * N + 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0] fail_elem;
  logic [DW-1:0] fail_expected, fail_data;
  logic sram_we;
  logic [WMW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  sram22_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WMW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_expected(fail_expected),
    .fail_data(fail_data), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM model with an optional single stuck-at bit seen on reads
  logic [DW-1:0] mem [N];
  bit fault_en;
  int fault_addr, fault_bit;
  bit fault_val;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = '0;
    m[fault_bit] = 1'b1;
    if (fault_en && a == fault_addr) return fault_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask[0]) mem[sram_addr] <= sram_din;
    end else begin
      sram_dout <= faulty(int'(sram_addr), mem[sram_addr]);
    end
  end

  int n_pass, n_checks;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct {
    bit we;
    int addr;
    logic [DW-1:0] data;
  } op_t;

  op_t exp_ops[$];
  int m_nops, m_done_edge;
  bit m_fail;
  int m_faddr, m_felem;
  logic [DW-1:0] m_fexp, m_fdata;

  bit cap_we [CAP];
  int cap_addr [CAP];
  logic [DW-1:0] cap_din [CAP];

  task automatic build_model();
    logic [DW-1:0] mm [N];
    int rd_bg [6] = '{0, 0, 1, 0, 1, 0};
    int wr_bg [6] = '{0, 1, 0, 1, 0, 0};
    int k, fk, a;
    logic [DW-1:0] v, bgw;
    op_t o;
    exp_ops.delete();
    k = 0; fk = -1;
    m_fail = 0; m_faddr = 0; m_felem = 0; m_fexp = '0; m_fdata = '0;
    for (int i = 0; i < N; i++) mm[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e > 0) begin
          k++;
          bgw = rd_bg[e] != 0 ? '1 : '0;
          o.we = 0; o.addr = a; o.data = bgw;
          exp_ops.push_back(o);
          v = faulty(a, mm[a]);
          if (fk < 0 && v !== bgw) begin
            fk = k; m_fail = 1; m_faddr = a; m_felem = e; m_fexp = bgw; m_fdata = v;
          end
        end
        if (e < 5) begin
          k++;
          bgw = wr_bg[e] != 0 ? '1 : '0;
          o.we = 1; o.addr = a; o.data = bgw;
          exp_ops.push_back(o);
          mm[a] = bgw;
        end
      end
    end
    if (fk >= 0) begin
      m_nops = fk + 1; m_done_edge = fk + 2;
    end else begin
      m_nops = k; m_done_edge = k + 1;
    end
  endtask

  task automatic run_test(input bit hold, input string name);
    int op_errs, idle_we_errs, mask_errs, flag_errs;
    op_t o;
    op_errs = 0; idle_we_errs = 0; mask_errs = 0; flag_errs = 0;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= m_done_edge + 3; c++) begin
      @(negedge clk);
      if (c < CAP) begin
        cap_we[c] = sram_we; cap_addr[c] = int'(sram_addr); cap_din[c] = sram_din;
      end
      if (c == 1) check({name, ":fail_cleared"}, {fail, fail_elem, fail_addr, fail_data}, 64'd0);
      if (c <= m_nops) begin
        o = exp_ops[c-1];
        if (sram_we !== o.we || int'(sram_addr) != o.addr || (o.we && sram_din !== o.data))
          op_errs++;
      end else if (sram_we !== 1'b0) begin
        idle_we_errs++;
      end
      if (sram_we && sram_wmask !== '1) mask_errs++;
      if (busy !== (c <= m_done_edge) || done !== (c > m_done_edge)) flag_errs++;
      if (!hold || c > m_done_edge) start = 1'b0;
    end
    check({name, ":op_stream_errs"}, op_errs, 0);
    check({name, ":we_after_stop"}, idle_we_errs, 0);
    check({name, ":wmask_errs"}, mask_errs, 0);
    check({name, ":busy_done_errs"}, flag_errs, 0);
    check({name, ":fail"}, fail, m_fail);
    check({name, ":fail_addr"}, fail_addr, m_faddr);
    check({name, ":fail_elem"}, fail_elem, m_felem);
    check({name, ":fail_expected"}, fail_expected, m_fexp);
    check({name, ":fail_data"}, fail_data, m_fdata);
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    reset = 1'b1; start = 1'b0; fault_en = 0; fault_addr = 0; fault_bit = 0; fault_val = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {busy, done, fail, sram_we, fail_elem, fail_addr}, 64'd0);
    check("reset_addr_din", {sram_addr, sram_din}, 64'd0);
    check("reset_fail_words", {fail_expected, fail_data}, 64'd0);
    check("reset_wmask", sram_wmask, 64'd1);
    reset = 1'b0;

    run_test(0, "clean");
    check("m1_first_r0", {cap_we[513], cap_addr[513][AW-1:0]}, {1'b0, 9'h000});
    check("m1_first_w1", {cap_we[514], cap_addr[514][AW-1:0], cap_din[514]}, {1'b1, 9'h000, 32'hFFFF_FFFF});
    check("m3_first_r0", {cap_we[2561], cap_addr[2561][AW-1:0]}, {1'b0, 9'h1FF});
    check("m3_first_w1", {cap_we[2562], cap_addr[2562][AW-1:0], cap_din[2562]}, {1'b1, 9'h1FF, 32'hFFFF_FFFF});

    fault_en = 1; fault_addr = 'h0A3; fault_bit = 5; fault_val = 1;
    run_test(0, "sa1_0a3");
    check("sa1_0a3_report", {fail, fail_elem, fail_addr, fail_expected, fail_data},
          {1'b1, 3'd1, 9'h0A3, 32'h0000_0000, 32'h0000_0020});

    for (int r = 0; r < 3; r++) begin
      fault_addr = int'($urandom_range(0, N - 1));
      fault_bit = int'($urandom_range(0, DW - 1));
      fault_val = 1'($urandom_range(0, 1));
      run_test(0, $sformatf("rand%0d", r));
    end

    fault_en = 0;
    run_test(1, "hold_start");
    run_test(0, "rerun");

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c < 1000; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset", {busy, sram_we, done, fail}, 64'd0);
    reset = 1'b0;
    run_test(0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
